// File: rtl/hms_counter.sv
// -----------------------------------------------------------------------------
// hms_counter
//   Time-of-day counter driven by the NCO's 1 Hz square wave. Each rising edge
//   of i_tick, seen in the clk domain, counts as one elapsed second. The counter
//   keeps binary seconds, minutes and hours with a full carry chain. A
//   four-state mode FSM lets the user set each field with pulse inputs.
//
// Parameters
//   HOUR_MOD     hour wrap modulus, 2..32
//
// Ports
//   clk          system clock; the NCO runs on the same clock
//   rst          asynchronous, active-high reset
//   i_tick       1 Hz square wave, already registered in clk
//   i_mode       1-cycle pulse: advance RUN -> SET_SEC -> SET_MIN -> SET_HOUR
//   i_inc        1-cycle pulse: increment the field selected by the mode
//   o_sec        seconds 0..59
//   o_min        minutes 0..59
//   o_hour       hours 0..HOUR_MOD-1
//   o_mode       0=RUN 1=SET_SEC 2=SET_MIN 3=SET_HOUR
//   o_sec_pulse  1-cycle pulse: a counted second was applied
//   o_day_wrap   1-cycle pulse: full-day rollover to 00:00:00
// -----------------------------------------------------------------------------
module hms_counter #(
  parameter int unsigned HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_mode,
  input  logic       i_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic       o_sec_pulse,
  output logic       o_day_wrap
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] SET_SEC  = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_HOUR = 2'd3;

  localparam logic [5:0] SIXTY_MAX = 6'd59;
  localparam logic [4:0] HOUR_MAX  = 5'(HOUR_MOD - 1);

  logic       tick_q;
  logic [5:0] sec_q,  sec_d;
  logic [5:0] min_q,  min_d;
  logic [4:0] hour_q, hour_d;
  logic [1:0] mode_q, mode_d;
  logic       pulse_q, pulse_d;
  logic       wrap_q,  wrap_d;
  logic       rise;

  // i_tick comes from the NCO on this same clock, so no synchronizer is needed.
  assign rise = i_tick & ~tick_q;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    mode_d  = mode_q;
    pulse_d = 1'b0;
    wrap_d  = 1'b0;

    // The mode advances independently of the field update below. That update
    // always acts on the pre-transition mode.
    if (i_mode) begin
      case (mode_q)
        RUN:      mode_d = SET_SEC;
        SET_SEC:  mode_d = SET_MIN;
        SET_MIN:  mode_d = SET_HOUR;
        default:  mode_d = RUN;
      endcase
    end

    case (mode_q)
      RUN: begin
        // Seconds, minutes and hours all resolve in one edge.
        if (rise) begin
          pulse_d = 1'b1;
          if (sec_q == SIXTY_MAX) begin
            sec_d = '0;
            if (min_q == SIXTY_MAX) begin
              min_d = '0;
              if (hour_q == HOUR_MAX) begin
                hour_d = '0;
                wrap_d = 1'b1;
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      SET_SEC: begin
        if (i_inc) sec_d = (sec_q == SIXTY_MAX) ? '0 : sec_q + 6'd1;
      end
      SET_MIN: begin
        if (i_inc) min_d = (min_q == SIXTY_MAX) ? '0 : min_q + 6'd1;
      end
      default: begin
        if (i_inc) hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then sample
  // their next-state values together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // tick_q resets high. A wave that is already high at reset release is
      // then not taken as a fresh rising edge.
      tick_q  <= 1'b1;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      mode_q  <= RUN;
      pulse_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q  <= i_tick;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_sec       = sec_q;
  assign o_min       = min_q;
  assign o_hour      = hour_q;
  assign o_mode      = mode_q;
  assign o_sec_pulse = pulse_q;
  assign o_day_wrap  = wrap_q;

endmodule

// File: tb/tb_hms_counter.sv
// -----------------------------------------------------------------------------
// tb_hms_counter
//   Directed bench for hms_counter. Each stimulus step updates a small
//   time-of-day model and pushes the expected outputs to a scoreboard queue.
//   The entry is popped and compared once the DUT has registered the step.
//   A second instance built with HOUR_MOD=12 shares the inputs. It is compared
//   only while both instances should agree, plus once at its hour wrap.
// -----------------------------------------------------------------------------
module tb_hms_counter;

  localparam int H = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick;
  logic       i_mode;
  logic       i_inc;
  logic [5:0] o_sec,  o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode;
  logic       o_sec_pulse, o_day_wrap;

  logic [5:0] h12_sec, h12_min;
  logic [4:0] h12_hour;
  logic [1:0] h12_mode;
  logic       h12_pulse, h12_wrap;

  always #5 clk = ~clk;

  hms_counter #(.HOUR_MOD(H)) u_dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_mode(i_mode), .i_inc(i_inc),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode),
    .o_sec_pulse(o_sec_pulse), .o_day_wrap(o_day_wrap)
  );

  hms_counter #(.HOUR_MOD(12)) u_dut12 (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_mode(i_mode), .i_inc(i_inc),
    .o_sec(h12_sec), .o_min(h12_min), .o_hour(h12_hour), .o_mode(h12_mode),
    .o_sec_pulse(h12_pulse), .o_day_wrap(h12_wrap)
  );

  // Pulse monitor: counts high cycles and rising edges of each pulse output.
  int pulse_hi = 0, pulse_edges = 0, wrap_hi = 0, wrap_edges = 0;
  bit pulse_prev = 1'b0, wrap_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_sec_pulse) pulse_hi++;
      if (o_sec_pulse && !pulse_prev) pulse_edges++;
      if (o_day_wrap) wrap_hi++;
      if (o_day_wrap && !wrap_prev) wrap_edges++;
    end
    pulse_prev = o_sec_pulse;
    wrap_prev  = o_day_wrap;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model of the time of day
  int m_sec = 0, m_min = 0, m_hour = 0, m_mode = 0;

  typedef struct {
    int sec;
    int min;
    int hour;
    int mode;
    bit pulse;
    bit wrap;
  } exp_t;
  exp_t sb_q[$];

  task automatic m_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0;
  endtask

  task automatic m_count(output bit p, output bit w);
    p = 1'b0;
    w = 1'b0;
    if (m_mode == 0) begin
      p = 1'b1;
      if (++m_sec == 60) begin
        m_sec = 0;
        if (++m_min == 60) begin
          m_min = 0;
          if (++m_hour == H) begin
            m_hour = 0;
            w = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic m_inc();
    case (m_mode)
      1:       m_sec  = (m_sec + 1) % 60;
      2:       m_min  = (m_min + 1) % 60;
      3:       m_hour = (m_hour + 1) % H;
      default: ;
    endcase
  endtask

  task automatic sb_push(input bit p, input bit w);
    sb_q.push_back('{m_sec, m_min, m_hour, m_mode, p, w});
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, "_sb_entry"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_sec"},   32'(o_sec),       32'(e.sec));
      check({tag, "_min"},   32'(o_min),       32'(e.min));
      check({tag, "_hour"},  32'(o_hour),      32'(e.hour));
      check({tag, "_mode"},  32'(o_mode),      32'(e.mode));
      check({tag, "_pulse"}, 32'(o_sec_pulse), 32'(e.pulse));
      check({tag, "_wrap"},  32'(o_day_wrap),  32'(e.wrap));
    end
  endtask

  // Each step starts and ends 1 time unit after a rising clock edge.
  task automatic step_pulse(input bit md, input bit inc, input string tag);
    i_mode = md;
    i_inc  = inc;
    if (inc) m_inc();
    if (md)  m_mode = (m_mode + 1) % 4;
    sb_push(1'b0, 1'b0);
    @(posedge clk); #1;
    i_mode = 1'b0;
    i_inc  = 1'b0;
    @(negedge clk);
    sb_check(tag);
    @(posedge clk); #1;
  endtask

  task automatic step_rise(input int hi, input int lo, input bit md, input string tag);
    bit p, w;
    i_tick = 1'b1;
    i_mode = md;
    m_count(p, w);
    if (md) m_mode = (m_mode + 1) % 4;
    sb_push(p, w);
    @(posedge clk); #1;
    i_mode = 1'b0;
    @(negedge clk);
    sb_check(tag);
    repeat (hi) @(posedge clk);
    #1 i_tick = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  int s_phi, s_pe, s_whi, s_we;
  task automatic snap();
    s_phi = pulse_hi; s_pe = pulse_edges; s_whi = wrap_hi; s_we = wrap_edges;
  endtask

  initial begin
    bit p, w;
    rst = 1'b1; i_tick = 1'b0; i_mode = 1'b0; i_inc = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_push(1'b0, 1'b0);
    sb_check("reset");
    check("reset_h12_mode", 32'(h12_mode), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Three rises, 50-cycle period. The first rise also checks latency.
    snap();
    i_tick = 1'b1;
    @(negedge clk);
    check("lat_before_edge_sec",   32'(o_sec),       32'd0);
    check("lat_before_edge_pulse", 32'(o_sec_pulse), 32'd0);
    m_count(p, w);
    sb_push(p, w);
    @(posedge clk);
    @(negedge clk);
    sb_check("rise1");
    @(negedge clk);
    check("rise1_pulse_drop", 32'(o_sec_pulse), 32'd0);
    repeat (23) @(posedge clk);
    #1 i_tick = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    step_rise(24, 25, 1'b0, "rise2");
    step_rise(24, 25, 1'b0, "rise3");
    check("three_rises_sec",         32'(o_sec),                 32'd3);
    check("three_rises_pulse_cyc",   32'(pulse_hi - s_phi),      32'd3);
    check("three_rises_pulse_edges", 32'(pulse_edges - s_pe),    32'd3);

    // i_inc is ignored in RUN
    step_pulse(1'b0, 1'b1, "run_inc_ignored");

    // Run to 00:00:10, then reset mid-cycle with the pulse in flight.
    // i_tick stays high through reset release.
    for (int i = 0; i < 6; i++) step_rise(1, 1, 1'b0, "to_sec9");
    i_tick = 1'b1;
    m_count(p, w);
    sb_push(p, w);
    @(posedge clk);
    @(negedge clk);
    sb_check("sec10");
    #1 rst = 1'b1;
    m_reset();
    #1;
    sb_push(1'b0, 1'b0);
    sb_check("rst_async");
    @(posedge clk); #1 rst = 1'b0;

    // i_tick high across release is not a rise
    snap();
    repeat (100) @(posedge clk);
    @(negedge clk);
    sb_push(1'b0, 1'b0);
    sb_check("tick_high_at_release");
    check("tick_high_no_pulse", 32'(pulse_hi - s_phi), 32'd0);
    @(posedge clk); #1 i_tick = 1'b0;
    @(posedge clk); #1;
    step_rise(2, 2, 1'b0, "first_rise_after_release");

    // SET_HOUR to 4, then mode and inc together
    for (int i = 0; i < 3; i++) step_pulse(1'b1, 1'b0, "to_set_hour");
    while (m_hour != 4) step_pulse(1'b0, 1'b1, "set_hour4");
    step_pulse(1'b1, 1'b1, "mode_inc_same_cycle");
    check("h12_hour_agree", 32'(h12_hour), 32'd5);

    // Mode and rise together in RUN: the second counts.
    // In SET_HOUR the rise is ignored.
    step_rise(2, 2, 1'b1, "rise_mode_in_run");
    for (int i = 0; i < 2; i++) step_pulse(1'b1, 1'b0, "to_set_hour_b");
    step_rise(2, 2, 1'b1, "rise_mode_in_set_hour");

    // HOUR_MOD=12 instance: 11 + inc -> 0
    for (int i = 0; i < 3; i++) step_pulse(1'b1, 1'b0, "to_set_hour_c");
    while (m_hour != 11) step_pulse(1'b0, 1'b1, "set_hour11");
    check("h12_at_11", 32'(h12_hour), 32'd11);
    step_pulse(1'b0, 1'b1, "hour11_inc");
    check("h12_hour_wrap", 32'(h12_hour), 32'((11 + 1) % 12));
    check("h12_mode",      32'(h12_mode), 32'd3);
    check("h12_no_wrap",   32'(h12_wrap), 32'd0);

    // Set 23:59:59, return to RUN, one rise gives a full rollover
    while (m_hour != 23) step_pulse(1'b0, 1'b1, "set_hour23");
    step_pulse(1'b1, 1'b0, "to_run");
    step_pulse(1'b1, 1'b0, "to_set_sec");
    while (m_sec != 59) step_pulse(1'b0, 1'b1, "set_sec59");
    step_pulse(1'b1, 1'b0, "to_set_min");
    while (m_min != 59) step_pulse(1'b0, 1'b1, "set_min59");
    step_pulse(1'b1, 1'b0, "to_set_hour_d");
    step_pulse(1'b1, 1'b0, "to_run_b");
    snap();
    step_rise(3, 3, 1'b0, "day_wrap");
    check("day_wrap_cycles",  32'(wrap_hi - s_whi),     32'd1);
    check("day_wrap_edges",   32'(wrap_edges - s_we),   32'd1);
    check("day_pulse_cycles", 32'(pulse_hi - s_phi),    32'd1);

    // SET_MIN from 7: 60 incs plus 2 rises return to 7 with no pulses
    for (int i = 0; i < 2; i++) step_pulse(1'b1, 1'b0, "to_set_min_b");
    while (m_min != 7) step_pulse(1'b0, 1'b1, "set_min7");
    snap();
    for (int i = 0; i < 60; i++) begin
      step_pulse(1'b0, 1'b1, "min_inc_loop");
      if (i == 20 || i == 40) step_rise(2, 2, 1'b0, "rise_in_set_min");
    end
    check("set_min_back_to_7", 32'(o_min),              32'd7);
    check("set_min_no_pulse",  32'(pulse_hi - s_phi),   32'd0);
    check("set_min_no_wrap",   32'(wrap_hi - s_whi),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
